// File: rtl/movement_scheduler_if.sv
`default_nettype none
// ============================================================================
//  Module      : movement_scheduler_if
//  Description : Button / frame-strobe inputs and movement-strobe outputs of
//                the movement scheduler, bundled with master/slave views.
//  Revision    : 1.0  initial release
// ============================================================================
interface movement_scheduler_if;
    logic       btn_fwd;
    logic       btn_bwd;
    logic       btn_left;
    logic       btn_right;
    logic       frame_done;
    logic       fwd_pulse;
    logic       bwd_pulse;
    logic       leftRot_pulse;
    logic       rightRot_pulse;
    logic [3:0] req_pending;
    logic       busy;

    modport master (
        output btn_fwd, btn_bwd, btn_left, btn_right, frame_done,
        input  fwd_pulse, bwd_pulse, leftRot_pulse, rightRot_pulse,
        input  req_pending, busy
    );

    modport slave (
        input  btn_fwd, btn_bwd, btn_left, btn_right, frame_done,
        output fwd_pulse, bwd_pulse, leftRot_pulse, rightRot_pulse,
        output req_pending, busy
    );
endinterface
`default_nettype wire

// File: rtl/movement_scheduler.sv
`default_nettype none
// ============================================================================
//  Module      : movement_scheduler
//  Description : Synchronizes and debounces four movement buttons, latches
//                press requests with auto-repeat, and grants at most one
//                one-cycle movement strobe per rendered frame.
//  Revision    : 1.0  initial release
// ============================================================================
module movement_scheduler #(
    parameter int DEBOUNCE_CYCLES = 1_000_000,
    parameter int REPEAT_FRAMES   = 8
) (
    input  logic                clk_in,
    input  logic                rst_in,
    movement_scheduler_if.slave bus
);
    localparam int                c_DB_W    = $clog2(DEBOUNCE_CYCLES + 1);
    localparam int                c_RP_W    = $clog2(REPEAT_FRAMES + 2);
    localparam logic [c_DB_W-1:0] c_DB_LAST = c_DB_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [0:0]        c_IDLE    = 1'b0;
    localparam logic [0:0]        c_ISSUE   = 1'b1;

    // Bit order throughout: {right, left, bwd, fwd}
    logic [3:0] w_raw;
    logic [3:0] r_sync1;
    logic [3:0] r_sync2;
    logic [3:0] w_rise;
    logic [3:0] w_rep_set;
    logic [3:0] w_set;
    logic [3:0] w_clr;
    logic [3:0] w_grant;
    logic       w_go;
    logic [3:0] r_req;
    logic [3:0] r_pulse;
    logic [0:0] r_state;

    assign w_raw = {bus.btn_right, bus.btn_left, bus.btn_bwd, bus.btn_fwd};

    // Two-flop synchronizer for the asynchronous button levels
    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            r_sync1 <= '0;
            r_sync2 <= '0;
        end else begin
            r_sync1 <= w_raw;
            r_sync2 <= r_sync1;
        end
    end

    generate
        for (genvar i = 0; i < 4; i++) begin : g_btn
            logic [c_DB_W-1:0] r_db_cnt;
            logic              r_lvl;
            logic              r_lvl_q;

            // Debounce: the level follows the sample only after DEBOUNCE_CYCLES consecutive disagreeing samples
            always_ff @(posedge clk_in) begin
                if (rst_in) begin
                    r_db_cnt <= '0;
                    r_lvl    <= 1'b0;
                    r_lvl_q  <= 1'b0;
                end else begin
                    r_lvl_q <= r_lvl;
                    if (r_sync2[i] != r_lvl) begin
                        if (r_db_cnt == c_DB_LAST) begin
                            r_lvl    <= r_sync2[i];
                            r_db_cnt <= '0;
                        end else begin
                            r_db_cnt <= r_db_cnt + 1'b1;
                        end
                    end else begin
                        r_db_cnt <= '0;
                    end
                end
            end

            // Rise is taken from the registered level so the request lands one cycle after it
            assign w_rise[i] = r_lvl & ~r_lvl_q;

            if (REPEAT_FRAMES > 0) begin : g_repeat
                localparam logic [c_RP_W-1:0] c_RP_LAST = c_RP_W'(REPEAT_FRAMES - 1);
                logic [c_RP_W-1:0] r_rp_cnt;
                logic              w_rp_hit;

                assign w_rp_hit = r_lvl & bus.frame_done & (r_rp_cnt == c_RP_LAST);

                // Frame counter for a held button; re-arms the request every REPEAT_FRAMES frames
                always_ff @(posedge clk_in) begin
                    if (rst_in || !r_lvl) begin
                        r_rp_cnt <= '0;
                    end else if (bus.frame_done) begin
                        r_rp_cnt <= w_rp_hit ? '0 : r_rp_cnt + 1'b1;
                    end
                end

                assign w_rep_set[i] = w_rp_hit;
            end else begin : g_no_repeat
                assign w_rep_set[i] = 1'b0;
            end
        end
    endgenerate

    assign w_set = w_rise | w_rep_set;

    // Grant selection from the registered request vector on a frame boundary
    always_comb begin
        w_clr   = '0;
        w_grant = '0;
        w_go    = 1'b0;
        if ((r_state == c_IDLE) && bus.frame_done && (r_req != 4'b0000)) begin
            if (r_req[0] && r_req[1]) begin
                // Opposing translations cancel; a pending rotation may still go
                w_clr[1:0] = 2'b11;
                if (r_req[2]) begin
                    w_grant = 4'b0100;
                end else if (r_req[3]) begin
                    w_grant = 4'b1000;
                end
            end else if (r_req[0]) begin
                w_grant = 4'b0001;
            end else if (r_req[1]) begin
                w_grant = 4'b0010;
            end else if (r_req[2]) begin
                w_grant = 4'b0100;
            end else begin
                w_grant = 4'b1000;
            end
            w_clr = w_clr | w_grant;
            w_go  = |w_grant;
        end
    end

    // Request register (set wins over clear), FSM state and the one-cycle strobes
    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            r_req   <= '0;
            r_pulse <= '0;
            r_state <= c_IDLE;
        end else begin
            r_req <= (r_req & ~w_clr) | w_set;
            if (w_go) begin
                r_state <= c_ISSUE;
                r_pulse <= w_grant;
            end else begin
                r_state <= c_IDLE;
                r_pulse <= '0;
            end
        end
    end

    assign bus.fwd_pulse      = r_pulse[0];
    assign bus.bwd_pulse      = r_pulse[1];
    assign bus.leftRot_pulse  = r_pulse[2];
    assign bus.rightRot_pulse = r_pulse[3];
    assign bus.req_pending    = r_req;
    assign bus.busy           = (r_state == c_ISSUE);
endmodule
`default_nettype wire

// File: tb/tb_movement_scheduler.sv
`default_nettype none
// ============================================================================
//  Module      : tb_movement_scheduler
//  Description : Self-checking bench for movement_scheduler; expected strobes
//                are queued with the frame number they must follow.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_movement_scheduler;
    localparam int DB    = 4;
    localparam int RF    = 3;
    localparam int FRAME = 50;

    typedef struct {
        int         frame;
        logic [3:0] code;
    } exp_t;

    logic clk_in = 1'b0;
    logic rst_in = 1'b1;
    int   errors = 0;
    int   checks = 0;
    int   frames = 0;
    int   fcnt   = 0;
    exp_t sb[$];

    movement_scheduler_if bus_if ();

    movement_scheduler #(
        .DEBOUNCE_CYCLES (DB),
        .REPEAT_FRAMES   (RF)
    ) dut (
        .clk_in (clk_in),
        .rst_in (rst_in),
        .bus    (bus_if)
    );

    wire [3:0] pulses = {bus_if.rightRot_pulse, bus_if.leftRot_pulse,
                         bus_if.bwd_pulse, bus_if.fwd_pulse};

    always #5 clk_in = ~clk_in;

    // Free-running frame strobe, one cycle high every FRAME cycles
    initial begin
        bus_if.frame_done = 1'b0;
        forever begin
            @(posedge clk_in);
            #1;
            fcnt = (fcnt == FRAME - 1) ? 0 : fcnt + 1;
            bus_if.frame_done = (fcnt == FRAME - 1);
        end
    end

    // Number of frame strobes the DUT has accepted outside reset
    always @(posedge clk_in) begin
        if (bus_if.frame_done === 1'b1 && rst_in === 1'b0) frames++;
    end

    // Output monitor: every strobe must be one-hot, flagged busy, and match the queue head
    always @(negedge clk_in) begin : mon
        exp_t e;
        if (pulses != 4'b0000) begin
            checks++;
            if (!$onehot(pulses)) begin
                errors++;
                $display("FAIL onehot: pulses=%b required one-hot", pulses);
            end
            checks++;
            if (bus_if.busy !== 1'b1) begin
                errors++;
                $display("FAIL busy_with_pulse: busy=%b required 1", bus_if.busy);
            end
            checks++;
            if (sb.size() == 0) begin
                errors++;
                $display("FAIL unexpected_pulse: pulses=%b after frame %0d, required none", pulses, frames);
            end else begin
                e = sb.pop_front();
                if (e.code !== pulses || e.frame != frames) begin
                    errors++;
                    $display("FAIL pulse: got %b after frame %0d, required %b after frame %0d",
                             pulses, frames, e.code, e.frame);
                end
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic set_btns(input logic [3:0] m);
        bus_if.btn_fwd   = m[0];
        bus_if.btn_bwd   = m[1];
        bus_if.btn_left  = m[2];
        bus_if.btn_right = m[3];
    endtask

    // Returns #1 after the edge at which the DUT sampled frame_done high
    task automatic sync_after_frame();
        do @(posedge clk_in); while (bus_if.frame_done !== 1'b1);
        #1;
    endtask

    task automatic wait_frames(input int n);
        repeat (n) sync_after_frame();
    endtask

    task automatic press(input logic [3:0] m, input int hold);
        set_btns(m);
        repeat (hold) @(posedge clk_in);
        #1;
        set_btns(4'b0000);
    endtask

    task automatic test_reset();
        rst_in = 1'b1;
        set_btns(4'b0000);
        repeat (4) @(posedge clk_in);
        @(negedge clk_in);
        checks++;
        if (pulses !== 4'b0000) begin
            errors++;
            $display("FAIL reset_pulses: got %b required 0000", pulses);
        end
        checks++;
        if (bus_if.req_pending !== 4'b0000) begin
            errors++;
            $display("FAIL reset_req: got %b required 0000", bus_if.req_pending);
        end
        checks++;
        if (bus_if.busy !== 1'b0) begin
            errors++;
            $display("FAIL reset_busy: got %b required 0", bus_if.busy);
        end
        @(posedge clk_in);
        #1;
        rst_in = 1'b0;
    endtask

    task automatic test_clean_press();
        int f;
        sync_after_frame();
        f = frames;
        sb.push_back('{frame: f + 1, code: 4'b0001});
        set_btns(4'b0001);
        repeat (6) @(posedge clk_in);
        @(negedge clk_in);
        checks++;
        if (bus_if.req_pending !== 4'b0000) begin
            errors++;
            $display("FAIL clean_req_early: got %b at cycle 6 required 0000", bus_if.req_pending);
        end
        @(posedge clk_in);
        @(negedge clk_in);
        checks++;
        if (bus_if.req_pending !== 4'b0001) begin
            errors++;
            $display("FAIL clean_req_set: got %b at cycle 7 required 0001", bus_if.req_pending);
        end
        repeat (13) @(posedge clk_in);
        #1;
        set_btns(4'b0000);
        wait_frames(3);
        checks++;
        if (sb.size() != 0) begin
            errors++;
            $display("FAIL clean_missing: %0d pulses outstanding required 0", sb.size());
        end
        checks++;
        if (bus_if.req_pending !== 4'b0000) begin
            errors++;
            $display("FAIL clean_req_after: got %b required 0000", bus_if.req_pending);
        end
    endtask

    task automatic test_bounce();
        logic saw;
        saw = 1'b0;
        sync_after_frame();
        for (int i = 0; i < 15; i++) begin
            bus_if.btn_left = ~i[0];
            repeat (2) begin
                @(negedge clk_in);
                if (bus_if.req_pending !== 4'b0000) saw = 1'b1;
                @(posedge clk_in);
                #1;
            end
        end
        bus_if.btn_left = 1'b0;
        wait_frames(2);
        checks++;
        if (saw !== 1'b0 || bus_if.req_pending !== 4'b0000) begin
            errors++;
            $display("FAIL bounce_req: seen_nonzero=%b req=%b required 0 and 0000", saw, bus_if.req_pending);
        end
    endtask

    task automatic test_priority();
        int f;
        sync_after_frame();
        f = frames;
        sb.push_back('{frame: f + 1, code: 4'b0010});
        sb.push_back('{frame: f + 2, code: 4'b1000});
        press(4'b1010, 20);
        sync_after_frame();
        @(negedge clk_in);
        checks++;
        if (bus_if.req_pending !== 4'b1000) begin
            errors++;
            $display("FAIL priority_remaining: got %b required 1000", bus_if.req_pending);
        end
        wait_frames(2);
        checks++;
        if (sb.size() != 0 || bus_if.req_pending !== 4'b0000) begin
            errors++;
            $display("FAIL priority_done: outstanding=%0d req=%b required 0 and 0000", sb.size(), bus_if.req_pending);
        end
    endtask

    task automatic test_conflict();
        int f;
        sync_after_frame();
        press(4'b0011, 20);
        @(negedge clk_in);
        checks++;
        if (bus_if.req_pending !== 4'b0011) begin
            errors++;
            $display("FAIL conflict_req: got %b required 0011", bus_if.req_pending);
        end
        sync_after_frame();
        @(negedge clk_in);
        checks++;
        if (bus_if.req_pending !== 4'b0000 || bus_if.busy !== 1'b0) begin
            errors++;
            $display("FAIL conflict_cancel: req=%b busy=%b required 0000 and 0", bus_if.req_pending, bus_if.busy);
        end
        sync_after_frame();
        f = frames;
        sb.push_back('{frame: f + 1, code: 4'b0100});
        press(4'b0111, 20);
        @(negedge clk_in);
        checks++;
        if (bus_if.req_pending !== 4'b0111) begin
            errors++;
            $display("FAIL conflict_rot_req: got %b required 0111", bus_if.req_pending);
        end
        sync_after_frame();
        @(negedge clk_in);
        checks++;
        if (bus_if.req_pending !== 4'b0000) begin
            errors++;
            $display("FAIL conflict_rot_clear: got %b required 0000", bus_if.req_pending);
        end
        wait_frames(1);
        checks++;
        if (sb.size() != 0) begin
            errors++;
            $display("FAIL conflict_missing: %0d pulses outstanding required 0", sb.size());
        end
    endtask

    task automatic test_auto_repeat();
        int f;
        sync_after_frame();
        f = frames;
        for (int k = 0; k < 4; k++) begin
            sb.push_back('{frame: f + 1 + k * RF, code: 4'b1000});
        end
        press(4'b1000, 10 * FRAME);
        wait_frames(3);
        checks++;
        if (sb.size() != 0) begin
            errors++;
            $display("FAIL repeat_missing: %0d pulses outstanding required 0", sb.size());
        end
        checks++;
        if (bus_if.req_pending !== 4'b0000) begin
            errors++;
            $display("FAIL repeat_req_after: got %b required 0000", bus_if.req_pending);
        end
    endtask

    task automatic test_reset_mid();
        sync_after_frame();
        press(4'b0010, 20);
        repeat (FRAME - 21) @(posedge clk_in);
        #1;
        rst_in = 1'b1;
        @(negedge clk_in);
        checks++;
        if (bus_if.req_pending !== 4'b0010) begin
            errors++;
            $display("FAIL rstmid_req_before: got %b required 0010", bus_if.req_pending);
        end
        @(posedge clk_in);
        @(negedge clk_in);
        checks++;
        if (pulses !== 4'b0000 || bus_if.req_pending !== 4'b0000 || bus_if.busy !== 1'b0) begin
            errors++;
            $display("FAIL rstmid_outputs: pulses=%b req=%b busy=%b required all 0",
                     pulses, bus_if.req_pending, bus_if.busy);
        end
        @(posedge clk_in);
        #1;
        rst_in = 1'b0;
        wait_frames(2);
        checks++;
        if (bus_if.req_pending !== 4'b0000 || sb.size() != 0) begin
            errors++;
            $display("FAIL rstmid_after: req=%b outstanding=%0d required 0000 and 0", bus_if.req_pending, sb.size());
        end
    endtask

    initial begin
        set_btns(4'b0000);
        test_reset();
        test_clean_press();
        test_bounce();
        test_priority();
        test_conflict();
        test_auto_repeat();
        test_reset_mid();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
`default_nettype wire
